mips_lsu: RTL and testbench

Multi-cycle load/store unit sitting directly downstream of the single-cycle `mips_core` datapath, between its ALU address/`rt` outputs and the data memory port. Accepts one load or store request at a time through a valid/ready handshake and checks alignment. Generates byte-lane write masks and replicated store data, waits on a variable-latency memory with a timeout, and returns sign/zero-extended load data or an error code. The core stalls its PC while `req_ready` is low or a response is pending.

---
 rtl/mips_lsu_pkg.sv | 52 +++++
 rtl/lsu_lane_align.sv | 75 +++++++
 rtl/mips_lsu.sv | 176 +++++++++++++++++
 tb/tb_mips_lsu.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_lsu_pkg.sv
// Shared types for the mips_lsu load/store unit.
// MIPS_LSU_UNALIGNED_EN enables LWL/LWR/SWL/SWR; otherwise they report UNSUP.
package mips_lsu_pkg;

  typedef enum logic [2:0] {
    OP_B  = 3'd0,
    OP_H  = 3'd1,
    OP_W  = 3'd2,
    OP_BU = 3'd3,
    OP_HU = 3'd4,
    OP_WL = 3'd5,
    OP_WR = 3'd6
  } lsu_op_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_ADE   = 2'd1,
    ERR_DBE   = 2'd2,
    ERR_UNSUP = 2'd3
  } lsu_err_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_t;

  localparam int CNT_W = 8;

  function automatic logic is_misaligned(
    input logic [2:0] op,
    input logic [1:0] k
  );
    is_misaligned = 1'b0;
    if (op == OP_H || op == OP_HU) begin
      is_misaligned = k[0];
    end
    if (op == OP_W) begin
      is_misaligned = |k;
    end
  endfunction

  // Encoding 3'd7 has no operation behind it in either build.
  function automatic logic is_unsup(input logic [2:0] op);
`ifdef MIPS_LSU_UNALIGNED_EN
    is_unsup = (op == 3'd7);
`else
    is_unsup = (op == 3'd7) || (op == OP_WL) || (op == OP_WR);
`endif
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for mips_lsu: store masks/data, load extract/extend.
// MIPS_LSU_UNALIGNED_EN adds the LWL/LWR merge and SWL/SWR lanes.
module lsu_lane_align
  import mips_lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  k,
  input  logic [31:0] st_data,
  input  logic [31:0] rt_old,
  input  logic [31:0] ld_word,
  output logic [3:0]  st_mask,
  output logic [31:0] st_lane,
  output logic [31:0] ld_result
);

  logic [4:0]  sh;
  logic [31:0] ld_shr;
  logic        sx;

  assign sh     = {k, 3'b000};
  assign ld_shr = ld_word >> sh;
  assign sx     = (op == OP_B) || (op == OP_H);

`ifdef MIPS_LSU_UNALIGNED_EN
  logic [4:0]  sh_inv;
  logic [31:0] lo_keep;
  logic [31:0] hi_keep;

  assign sh_inv  = {~k, 3'b000};
  assign lo_keep = ~(32'hFFFF_FFFF << sh_inv);
  assign hi_keep = ~(32'hFFFF_FFFF >> sh);
`else
  logic unused_rt;
  assign unused_rt = ^rt_old;
`endif

  always_comb begin
    st_mask   = '0;
    st_lane   = '0;
    ld_result = '0;
    unique case (op)
      OP_B, OP_BU: begin
        st_mask   = 4'b0001 << k;
        st_lane   = {4{st_data[7:0]}};
        ld_result = {{24{ld_shr[7] & sx}}, ld_shr[7:0]};
      end
      OP_H, OP_HU: begin
        st_mask   = 4'b0011 << k;
        st_lane   = {2{st_data[15:0]}};
        ld_result = {{16{ld_shr[15] & sx}}, ld_shr[15:0]};
      end
      OP_W: begin
        st_mask   = 4'b1111;
        st_lane   = st_data;
        ld_result = ld_shr;
      end
`ifdef MIPS_LSU_UNALIGNED_EN
      OP_WL: begin
        st_mask   = 4'b1111 >> ~k;
        st_lane   = st_data >> sh_inv;
        ld_result = (ld_word << sh_inv) | (rt_old & lo_keep);
      end
      OP_WR: begin
        st_mask   = 4'b1111 << k;
        st_lane   = st_data << sh;
        ld_result = ld_shr | (rt_old & hi_keep);
      end
`endif
      default: begin
        st_mask = '0;
      end
    endcase
  end

endmodule

// File: rtl/mips_lsu.sv
// Multi-cycle load/store unit between mips_core and data memory.
// Build with MIPS_LSU_UNALIGNED_EN to support LWL/LWR/SWL/SWR.
module mips_lsu
  import mips_lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic        req_store,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_rt_old,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [1:0]  resp_err,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_data_in,
  output logic [3:0]  mem_write_en,
  output logic        mem_rd_en,
  input  logic [31:0] mem_data_out,
  input  logic        mem_ready,
  input  logic        mem_excpt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_t        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [1:0]        k_q, k_d;
  logic              store_q, store_d;
  logic [31:0]       rt_old_q, rt_old_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_data_q, resp_data_d;
  logic [1:0]        resp_err_q, resp_err_d;
  logic [29:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_data_in_q, mem_data_in_d;
  logic [3:0]        mem_write_en_q, mem_write_en_d;
  logic              mem_rd_en_q, mem_rd_en_d;

  logic              idle;
  logic [2:0]        la_op;
  logic [1:0]        la_k;
  logic [3:0]        la_mask;
  logic [31:0]       la_lane;
  logic [31:0]       la_ld;

  assign idle  = (state_q == ST_IDLE);

  // Stores are steered from the live request; loads from the latched one.
  assign la_op = idle ? req_op : op_q;
  assign la_k  = idle ? req_addr[1:0] : k_q;

  lsu_lane_align u_align (
    .op        (la_op),
    .k         (la_k),
    .st_data   (req_wdata),
    .rt_old    (rt_old_q),
    .ld_word   (mem_data_out),
    .st_mask   (la_mask),
    .st_lane   (la_lane),
    .ld_result (la_ld)
  );

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    k_d            = k_q;
    store_d        = store_q;
    rt_old_d       = rt_old_q;
    cnt_d          = cnt_q;
    resp_valid_d   = 1'b0;
    resp_data_d    = resp_data_q;
    resp_err_d     = resp_err_q;
    mem_addr_d     = mem_addr_q;
    mem_data_in_d  = mem_data_in_q;
    mem_write_en_d = mem_write_en_q;
    mem_rd_en_d    = mem_rd_en_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d     = req_op;
          k_d      = req_addr[1:0];
          store_d  = req_store;
          rt_old_d = req_rt_old;
          if (is_unsup(req_op) ||
              is_misaligned(req_op, req_addr[1:0])) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_data_d  = '0;
            resp_err_d   = is_unsup(req_op) ? ERR_UNSUP : ERR_ADE;
          end else begin
            state_d        = ST_ACCESS;
            cnt_d          = '0;
            mem_addr_d     = req_addr[31:2];
            mem_write_en_d = req_store ? la_mask : 4'b0000;
            mem_data_in_d  = req_store ? la_lane : 32'h0;
            mem_rd_en_d    = ~req_store;
          end
        end
      end
      ST_ACCESS: begin
        if (mem_excpt || mem_ready || cnt_q == CNT_LAST) begin
          state_d        = ST_RESP;
          resp_valid_d   = 1'b1;
          mem_addr_d     = '0;
          mem_data_in_d  = '0;
          mem_write_en_d = '0;
          mem_rd_en_d    = 1'b0;
          // Exception beats ready; no ready at all means timeout.
          if (mem_excpt || !mem_ready) begin
            resp_err_d  = ERR_DBE;
            resp_data_d = '0;
          end else begin
            resp_err_d  = ERR_NONE;
            resp_data_d = store_q ? 32'h0 : la_ld;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q        <= ST_IDLE;
      op_q           <= '0;
      k_q            <= '0;
      store_q        <= 1'b0;
      rt_old_q       <= '0;
      cnt_q          <= '0;
      resp_valid_q   <= 1'b0;
      resp_data_q    <= '0;
      resp_err_q     <= '0;
      mem_addr_q     <= '0;
      mem_data_in_q  <= '0;
      mem_write_en_q <= '0;
      mem_rd_en_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      k_q            <= k_d;
      store_q        <= store_d;
      rt_old_q       <= rt_old_d;
      cnt_q          <= cnt_d;
      resp_valid_q   <= resp_valid_d;
      resp_data_q    <= resp_data_d;
      resp_err_q     <= resp_err_d;
      mem_addr_q     <= mem_addr_d;
      mem_data_in_q  <= mem_data_in_d;
      mem_write_en_q <= mem_write_en_d;
      mem_rd_en_q    <= mem_rd_en_d;
    end
  end

  assign req_ready    = idle;
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign resp_err     = resp_err_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data_in  = mem_data_in_q;
  assign mem_write_en = mem_write_en_q;
  assign mem_rd_en    = mem_rd_en_q;

endmodule

// File: tb/tb_mips_lsu.sv
// Randomized bench for mips_lsu against a byte-level transaction model.
// Honours MIPS_LSU_UNALIGNED_EN the same way as the RTL build.
module tb_mips_lsu;

  localparam int TO = 4;

  localparam logic [2:0] B  = 3'd0;
  localparam logic [2:0] H  = 3'd1;
  localparam logic [2:0] W  = 3'd2;
  localparam logic [2:0] BU = 3'd3;
  localparam logic [2:0] HU = 3'd4;
  localparam logic [2:0] WL = 3'd5;
  localparam logic [2:0] WR = 3'd6;

  localparam logic [1:0] E_NONE  = 2'd0;
  localparam logic [1:0] E_ADE   = 2'd1;
  localparam logic [1:0] E_DBE   = 2'd2;
  localparam logic [1:0] E_UNSUP = 2'd3;

`ifdef MIPS_LSU_UNALIGNED_EN
  localparam bit UNAL = 1'b1;
`else
  localparam bit UNAL = 1'b0;
`endif

  logic        clk;
  logic        rst_b;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic        req_store;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_rt_old;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [1:0]  resp_err;
  logic [29:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [3:0]  mem_write_en;
  logic        mem_rd_en;
  logic [31:0] mem_data_out;
  logic        mem_ready;
  logic        mem_excpt;

  mips_lsu #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_store    (req_store),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_rt_old   (req_rt_old),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_write_en (mem_write_en),
    .mem_rd_en    (mem_rd_en),
    .mem_data_out (mem_data_out),
    .mem_ready    (mem_ready),
    .mem_excpt    (mem_excpt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs for the current cycle, set by the driver.
  bit          chk_en   = 1'b0;
  logic        e_ready  = 1'b1;
  logic        e_rvalid = 1'b0;
  logic        e_access = 1'b0;
  logic        e_store  = 1'b0;
  logic        e_rd     = 1'b0;
  logic [29:0] e_addr   = '0;
  logic [3:0]  e_mask   = '0;
  logic [31:0] e_din    = '0;
  logic [31:0] e_data   = '0;
  logic [1:0]  e_err    = '0;

  logic [31:0] last_data;
  logic [1:0]  last_err;
  logic [29:0] last_addr;
  logic [3:0]  last_mask;
  logic [31:0] last_din;
  int          resp_cyc;
  int          acc_cyc;
  int          rd_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)",
                  name, got, exp, $time);
  endtask

  always @(negedge clk) begin
    if (resp_valid) begin
      last_data = resp_data;
      last_err  = resp_err;
      resp_cyc  = cyc;
    end
    if (mem_rd_en) rd_cnt++;
    if (mem_rd_en || (|mem_write_en)) begin
      last_addr = mem_addr;
      last_mask = mem_write_en;
      last_din  = mem_data_in;
    end
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("resp_valid", 32'(resp_valid), 32'(e_rvalid));
      if (e_rvalid) begin
        chk("resp_data", resp_data, e_data);
        chk("resp_err", 32'(resp_err), 32'(e_err));
      end
      if (e_access) begin
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("mem_rd_en", 32'(mem_rd_en), 32'(e_rd));
        chk("mem_write_en", 32'(mem_write_en), 32'(e_mask));
        if (e_store) chk("mem_data_in", mem_data_in, e_din);
      end else begin
        chk("idle_mem_addr", 32'(mem_addr), 32'h0);
        chk("idle_mem_data_in", mem_data_in, 32'h0);
        chk("idle_mem_write_en", 32'(mem_write_en), 32'h0);
        chk("idle_mem_rd_en", 32'(mem_rd_en), 32'h0);
      end
    end
  end

  // kind: 0 = ready, 1 = excpt, 2 = both, at access cycle ev (1-based).
  function automatic void model(
    input  logic [2:0]  op,
    input  logic        st,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rt_old,
    input  logic [31:0] word,
    input  int          ev,
    input  int          kind,
    output logic [1:0]  err,
    output logic [31:0] data,
    output logic [3:0]  mask,
    output logic [31:0] din,
    output int          len
  );
    logic [7:0] mb[4];
    logic [7:0] rb[4];
    logic [7:0] wb[4];
    logic [7:0] ob[4];
    int k;
    for (int j = 0; j < 4; j++) begin
      mb[j] = word[8*j +: 8];
      rb[j] = rt_old[8*j +: 8];
      wb[j] = wdata[8*j +: 8];
      ob[j] = 8'h00;
    end
    k    = int'(addr[1:0]);
    err  = E_NONE;
    data = '0;
    mask = '0;
    din  = '0;
    len  = 0;
    if (op == 3'd7 || ((op == WL || op == WR) && !UNAL)) begin
      err = E_UNSUP;
      return;
    end
    if (((op == H || op == HU) && (k % 2 == 1)) || (op == W && k != 0)) begin
      err = E_ADE;
      return;
    end
    len = (ev <= TO) ? ev : TO;
    if (ev > TO || kind != 0) err = E_DBE;
    if (st) begin
      for (int j = 0; j < 4; j++) begin
        case (op)
          B, BU: begin mask[j] = (j == k); ob[j] = wb[0]; end
          H, HU: begin mask[j] = (j == k || j == k + 1); ob[j] = wb[j % 2]; end
          W:     begin mask[j] = 1'b1; ob[j] = wb[j]; end
          WL:    begin mask[j] = (j <= k); if (j <= k) ob[j] = wb[j + 3 - k]; end
          WR:    begin mask[j] = (j >= k); if (j >= k) ob[j] = wb[j - k]; end
          default: ;
        endcase
      end
      din = {ob[3], ob[2], ob[1], ob[0]};
    end else if (err == E_NONE) begin
      case (op)
        B:  data = 32'($signed(mb[k]));
        BU: data = 32'(mb[k]);
        H:  data = 32'($signed({mb[k + 1], mb[k]}));
        HU: data = 32'({mb[k + 1], mb[k]});
        W:  data = word;
        WL: begin
          for (int j = 0; j < 4; j++)
            ob[j] = (j >= 3 - k) ? mb[j - 3 + k] : rb[j];
          data = {ob[3], ob[2], ob[1], ob[0]};
        end
        WR: begin
          for (int j = 0; j < 4; j++)
            ob[j] = (j <= 3 - k) ? mb[j + k] : rb[j];
          data = {ob[3], ob[2], ob[1], ob[0]};
        end
        default: ;
      endcase
    end
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(
    input logic [2:0]  op,
    input logic        st,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input logic [31:0] rt_old,
    input int          ev,
    input int          kind,
    input logic [31:0] word
  );
    logic [1:0]  m_err;
    logic [31:0] m_data;
    logic [3:0]  m_mask;
    logic [31:0] m_din;
    int          m_len;
    model(op, st, addr, wdata, rt_old, word, ev, kind,
          m_err, m_data, m_mask, m_din, m_len);
    req_valid    = 1'b1;
    req_op       = op;
    req_store    = st;
    req_addr     = addr;
    req_wdata    = wdata;
    req_rt_old   = rt_old;
    mem_ready    = 1'($urandom);
    mem_excpt    = 1'($urandom);
    mem_data_out = $urandom;
    acc_cyc      = cyc;
    next_cycle();
    for (int i = 1; i <= m_len; i++) begin
      req_valid    = 1'($urandom);
      req_op       = 3'($urandom_range(0, 6));
      req_addr     = $urandom;
      req_store    = 1'($urandom);
      e_ready      = 1'b0;
      e_access     = 1'b1;
      e_rvalid     = 1'b0;
      e_store      = st;
      e_addr       = addr[31:2];
      e_rd         = ~st;
      e_mask       = st ? m_mask : 4'b0000;
      e_din        = m_din;
      mem_ready    = (i == ev) && (kind != 1);
      mem_excpt    = (i == ev) && (kind != 0);
      mem_data_out = (i == ev) ? word : $urandom;
      next_cycle();
    end
    e_ready      = 1'b0;
    e_access     = 1'b0;
    e_rvalid     = 1'b1;
    e_data       = m_data;
    e_err        = m_err;
    req_valid    = 1'($urandom);
    mem_ready    = 1'($urandom);
    mem_excpt    = 1'($urandom);
    mem_data_out = $urandom;
    next_cycle();
    e_rvalid  = 1'b0;
    e_ready   = 1'b1;
    req_valid = 1'b0;
    mem_ready = 1'b0;
    mem_excpt = 1'b0;
  endtask

  initial begin
    int rd_snap;
    logic [2:0] sops [5] = '{B, H, W, WL, WR};
    rst_b        = 1'b0;
    req_valid    = 1'b0;
    req_op       = '0;
    req_store    = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    req_rt_old   = '0;
    mem_data_out = '0;
    mem_ready    = 1'b0;
    mem_excpt    = 1'b0;
    chk_en       = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'h0);
    rst_b = 1'b1;
    next_cycle();

    run_txn(W, 1'b0, 32'h1000_0004, 32'h0, 32'h0, 1, 0, 32'hDEAD_BEEF);
    chk("lw_data", last_data, 32'hDEAD_BEEF);
    chk("lw_latency", 32'(resp_cyc - acc_cyc), 32'd2);
    chk("lw_mem_addr", 32'(last_addr), 32'h0400_0001);

    run_txn(B, 1'b0, 32'h0000_2003, 32'h0, 32'h0, 1, 0, 32'h80FF_0000);
    chk("lb_data", last_data, 32'hFFFF_FF80);
    run_txn(BU, 1'b0, 32'h0000_2003, 32'h0, 32'h0, 1, 0, 32'h80FF_0000);
    chk("lbu_data", last_data, 32'h0000_0080);

    run_txn(H, 1'b1, 32'h0000_3002, 32'h1234_ABCD, 32'h0, 1, 0, $urandom);
    chk("sh_mask", 32'(last_mask), 32'hC);
    chk("sh_din", last_din, 32'hABCD_ABCD);
    chk("sh_resp_data", last_data, 32'h0);
    chk("sh_err", 32'(last_err), 32'(E_NONE));

    rd_snap = rd_cnt;
    run_txn(W, 1'b0, 32'h0000_4001, 32'h0, 32'h0, 1, 0, $urandom);
    chk("ade_err", 32'(last_err), 32'(E_ADE));
    chk("ade_latency", 32'(resp_cyc - acc_cyc), 32'd1);
    chk("ade_no_rd", 32'(rd_cnt - rd_snap), 32'd0);

    run_txn(W, 1'b0, 32'h0000_5000, 32'h0, 32'h0, 99, 0, $urandom);
    chk("timeout_err", 32'(last_err), 32'(E_DBE));
    chk("timeout_latency", 32'(resp_cyc - acc_cyc), 32'd5);

    run_txn(W, 1'b0, 32'h0000_5000, 32'h0, 32'h0, 2, 2, 32'h1111_2222);
    chk("excpt_err", 32'(last_err), 32'(E_DBE));
    chk("excpt_latency", 32'(resp_cyc - acc_cyc), 32'd3);
    chk("excpt_data", last_data, 32'h0);

    run_txn(WL, 1'b0, 32'h0000_6001, 32'h0, 32'hAABB_CCDD, 1, 0,
            32'h4433_2211);
`ifdef MIPS_LSU_UNALIGNED_EN
    chk("lwl_data", last_data, 32'h2211_CCDD);
    chk("lwl_latency", 32'(resp_cyc - acc_cyc), 32'd2);
`else
    chk("lwl_err", 32'(last_err), 32'(E_UNSUP));
    chk("lwl_latency", 32'(resp_cyc - acc_cyc), 32'd1);
`endif

    for (int t = 0; t < 400; t++) begin
      logic        st;
      logic [2:0]  op;
      logic [31:0] addr;
      int          kind;
      st   = 1'($urandom);
      op   = st ? sops[$urandom_range(0, 4)] : 3'($urandom_range(0, 6));
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      kind = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      run_txn(op, st, addr, $urandom, $urandom, $urandom_range(1, TO + 2),
              kind, $urandom);
      repeat ($urandom_range(0, 2)) next_cycle();
    end

    req_valid  = 1'b1;
    req_op     = W;
    req_store  = 1'b0;
    req_addr   = 32'h0000_7000;
    mem_ready  = 1'b0;
    mem_excpt  = 1'b0;
    next_cycle();
    chk_en    = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("ar_rd_before", 32'(mem_rd_en), 32'h1);
    #1 rst_b = 1'b0;
    #1;
    chk("ar_rd_en", 32'(mem_rd_en), 32'h0);
    chk("ar_mem_addr", 32'(mem_addr), 32'h0);
    chk("ar_req_ready", 32'(req_ready), 32'h1);
    #1 rst_b = 1'b1;
    e_ready  = 1'b1;
    e_access = 1'b0;
    e_rvalid = 1'b0;
    next_cycle();
    chk_en = 1'b1;
    repeat (2) next_cycle();
    run_txn(HU, 1'b0, 32'h0000_8002, 32'h0, 32'h0, 1, 0, 32'h8001_0000);
    chk("post_rst_data", last_data, 32'h0000_8001);

    repeat (2) next_cycle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
